id_exe_stage_reg: RTL and testbench
===================================

ID_EXE_STAGE_REG -- requirements
Module: id_exe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of PC, operand and immediate-extension datapaths.
REQ-002 SHALL have parameter RADDR_W, default 4, register-index width, matching the 16-entry ARM register space.
REQ-003 SHALL have port clk  input  1  pipeline clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  branch-taken or hazard bubble request; clears the stage.
REQ-006 SHALL have port freeze  input  1  memory-stall hold; stage keeps its contents.
REQ-007 SHALL have inputs valid_in (1), pc_in (DATA_W), reg1_in (DATA_W), reg2_in (DATA_W), dest_in (RADDR_W), src1_in (RADDR_W), src2_in (RADDR_W) from ID; reg1_in/reg2_in are the register-file read ports.
REQ-008 SHALL have inputs exe_cmd_in (4), wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in (1 each), shift_operand_in (12), signed_imm24_in (24), status_in (4, NZCV).
REQ-009 SHALL have one registered output per input in REQ-007/008, same width, suffix _out.
REQ-010 SHALL have output bubble_cnt  output  8  saturating count of bubbles inserted since reset.

Function
REQ-011 On posedge clk with flush=1: valid, wb_en, mem_r_en, mem_w_en, b, s outputs SHALL load 0; all data fields SHALL load 0.
REQ-012 On posedge clk with flush=0, freeze=1: every output SHALL hold its value.
REQ-013 On posedge clk with flush=0, freeze=0: every output SHALL load its corresponding input; latency exactly 1 cycle.
REQ-014 flush and freeze both 1 SHALL behave as flush (flush has priority).
REQ-015 With valid_in=0 and no flush/freeze, control outputs (wb_en, mem_r_en, mem_w_en, b, s) SHALL load 0 regardless of their inputs; data fields load normally.
REQ-016 bubble_cnt SHALL increment by 1 on every posedge where flush=1 or (freeze=0 and valid_in=0); SHALL saturate at 255, never wrap.
REQ-017 bubble_cnt SHALL not change while freeze=1 and flush=0.
REQ-018 No combinational path from any input to any output.
REQ-019 Control outputs SHALL never be 1 while valid_out=0.

Reset
REQ-020 rst=1 SHALL immediately, without clk, drive every output including bubble_cnt to 0.
REQ-021 rst asserted mid-stall (freeze=1) SHALL still clear all state; first posedge after rst deasserts SHALL apply REQ-011..013 normally.
REQ-022 Reset state SHALL equal a flushed bubble, so EXE sees no write-back or memory access.

Structure
REQ-023 Control-field widths (exe_cmd 4, status 4, shift_operand 12, imm24 24) and the zero bubble value SHALL live in the shared pipeline package, shared with the IF/ID and EXE/MEM stage registers.
REQ-024 SHALL contain one sub-module, pipe_field_reg: parameterised-width register with rst/flush/freeze/load, instantiated per field group.
REQ-025 bubble_cnt logic SHALL be local to the top module.

Verification
REQ-026 rst pulse, then valid_in=1, pc_in=0x0000_0010, reg1_in=0x5, reg2_in=0x7, wb_en_in=1, exe_cmd_in=0x2, one clk -> outputs equal inputs next cycle, bubble_cnt=0.
REQ-027 Loaded stage, freeze=1 for 3 cycles while inputs change to pc_in=0x14 -> pc_out stays 0x10, bubble_cnt unchanged; freeze=0 -> pc_out=0x14 after 1 cycle.
REQ-028 flush=1 and freeze=1 together, wb_en_in=1, mem_w_en_in=1 -> next cycle valid_out=0, wb_en_out=0, mem_w_en_out=0, all data 0, bubble_cnt+1.
REQ-029 valid_in=0 with mem_r_en_in=1, reg1_in=0xAB -> mem_r_en_out=0, reg1_out=0xAB, bubble_cnt+1.
REQ-030 flush held 300 cycles -> bubble_cnt reaches 255 and stays 255.
REQ-031 rst asserted asynchronously mid-cycle during freeze with loaded stage -> all outputs 0 before next posedge.

Source files
------------

// File: rtl/id_exe_stage_reg_pkg.sv
// id_exe_stage_reg_pkg: shared pipeline field widths, control bundle and bubble values
package id_exe_stage_reg_pkg;

    localparam int EXE_CMD_W    = 4;
    localparam int STATUS_W     = 4;
    localparam int SHIFT_OP_W   = 12;
    localparam int IMM24_W      = 24;
    localparam int BUBBLE_CNT_W = 8;

    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic b;
        logic s;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // An invalid instruction must never reach EXE with side effects enabled.
    function automatic ctrl_t gate_ctrl(input logic valid, input ctrl_t ctrl);
        return valid ? ctrl : CTRL_BUBBLE;
    endfunction

endpackage

// File: rtl/id_exe_stage_reg_pipe_field_reg.sv
// pipe_field_reg: field-group register with async reset, flush-to-bubble and freeze-hold
module pipe_field_reg
    import id_exe_stage_reg_pkg::*;
#(
    parameter int             W      = 1,
    parameter logic [W-1:0]   BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         freeze,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q, q_d;

    // Flush wins over freeze; freeze holds; otherwise load.
    always_comb q_d = flush ? BUBBLE : (freeze ? q_q : d_i);

    // Reset state is the bubble so EXE sees no side effects.
    always_ff @(posedge clk or posedge rst)
        if (rst) q_q <= BUBBLE;
        else     q_q <= q_d;

    assign q_o = q_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register with flush, freeze and bubble counter
module id_exe_stage_reg
    import id_exe_stage_reg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    freeze,
    input  logic                    valid_in,
    input  logic [DATA_W-1:0]       pc_in,
    input  logic [DATA_W-1:0]       reg1_in,
    input  logic [DATA_W-1:0]       reg2_in,
    input  logic [RADDR_W-1:0]      dest_in,
    input  logic [RADDR_W-1:0]      src1_in,
    input  logic [RADDR_W-1:0]      src2_in,
    input  logic [EXE_CMD_W-1:0]    exe_cmd_in,
    input  logic                    wb_en_in,
    input  logic                    mem_r_en_in,
    input  logic                    mem_w_en_in,
    input  logic                    b_in,
    input  logic                    s_in,
    input  logic                    imm_in,
    input  logic [SHIFT_OP_W-1:0]   shift_operand_in,
    input  logic [IMM24_W-1:0]      signed_imm24_in,
    input  logic [STATUS_W-1:0]     status_in,
    output logic                    valid_out,
    output logic [DATA_W-1:0]       pc_out,
    output logic [DATA_W-1:0]       reg1_out,
    output logic [DATA_W-1:0]       reg2_out,
    output logic [RADDR_W-1:0]      dest_out,
    output logic [RADDR_W-1:0]      src1_out,
    output logic [RADDR_W-1:0]      src2_out,
    output logic [EXE_CMD_W-1:0]    exe_cmd_out,
    output logic                    wb_en_out,
    output logic                    mem_r_en_out,
    output logic                    mem_w_en_out,
    output logic                    b_out,
    output logic                    s_out,
    output logic                    imm_out,
    output logic [SHIFT_OP_W-1:0]   shift_operand_out,
    output logic [IMM24_W-1:0]      signed_imm24_out,
    output logic [STATUS_W-1:0]     status_out,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

    localparam int DW = 3 * DATA_W + 3 * RADDR_W + EXE_CMD_W + 1 + SHIFT_OP_W + IMM24_W + STATUS_W;

    ctrl_t ctrl_in, ctrl_gated, ctrl_q;
    logic [DW-1:0] data_in, data_q;
    logic bubble;
    logic [BUBBLE_CNT_W-1:0] cnt_q, cnt_d;

    assign ctrl_in    = '{wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in, b: b_in, s: s_in};
    assign ctrl_gated = gate_ctrl(valid_in, ctrl_in);
    assign data_in    = {pc_in, reg1_in, reg2_in, dest_in, src1_in, src2_in, exe_cmd_in,
                         imm_in, shift_operand_in, signed_imm24_in, status_in};

    pipe_field_reg #(.W(1)) u_valid (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .d_i(valid_in), .q_o(valid_out)
    );

    pipe_field_reg #(.W($bits(ctrl_t)), .BUBBLE(CTRL_BUBBLE)) u_ctrl (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .d_i(ctrl_gated), .q_o(ctrl_q)
    );

    pipe_field_reg #(.W(DW)) u_data (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .d_i(data_in), .q_o(data_q)
    );

    assign {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out} = ctrl_q;
    assign {pc_out, reg1_out, reg2_out, dest_out, src1_out, src2_out, exe_cmd_out,
            imm_out, shift_operand_out, signed_imm24_out, status_out} = data_q;

    assign bubble = flush | (~freeze & ~valid_in);

    // Count inserted bubbles, saturating at all-ones.
    always_comb cnt_d = (bubble && cnt_q != '1) ? cnt_q + BUBBLE_CNT_W'(1) : cnt_q;

    // Bubble counter register, cleared by reset only.
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
module tb_id_exe_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  exe_cmd;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic        imm;
        logic [11:0] shift;
        logic [23:0] imm24;
        logic [3:0]  status;
    } stage_t;

    logic clk = 0, rst, flush, freeze;
    stage_t in_s, got, exp_s;
    int exp_cnt;
    int n_checks = 0, n_fail = 0;

    logic        valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [31:0] pc_in, reg1_in, reg2_in;
    logic [3:0]  dest_in, src1_in, src2_in, exe_cmd_in, status_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm24_in;
    logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
    logic [31:0] pc_out, reg1_out, reg2_out;
    logic [3:0]  dest_out, src1_out, src2_out, exe_cmd_out, status_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm24_out;
    logic [7:0]  bubble_cnt;

    assign {valid_in, pc_in, reg1_in, reg2_in, dest_in, src1_in, src2_in, exe_cmd_in, wb_en_in,
            mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, shift_operand_in, signed_imm24_in,
            status_in} = in_s;
    assign got = {valid_out, pc_out, reg1_out, reg2_out, dest_out, src1_out, src2_out, exe_cmd_out,
                  wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, shift_operand_out,
                  signed_imm24_out, status_out};

    id_exe_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .valid_in(valid_in), .pc_in(pc_in), .reg1_in(reg1_in), .reg2_in(reg2_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .exe_cmd_in(exe_cmd_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .shift_operand_in(shift_operand_in),
        .signed_imm24_in(signed_imm24_in), .status_in(status_in),
        .valid_out(valid_out), .pc_out(pc_out), .reg1_out(reg1_out), .reg2_out(reg2_out),
        .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .exe_cmd_out(exe_cmd_out),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .b_out(b_out), .s_out(s_out), .imm_out(imm_out), .shift_operand_out(shift_operand_out),
        .signed_imm24_out(signed_imm24_out), .status_out(status_out), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference: one clock of the stage as the behavioural rules describe it.
    task automatic step(input logic fl, input logic fz);
        flush  = fl;
        freeze = fz;
        if (fl) exp_s = '0;
        else if (!fz) begin
            exp_s = in_s;
            if (!in_s.valid) {exp_s.wb_en, exp_s.mem_r_en, exp_s.mem_w_en, exp_s.b, exp_s.s} = '0;
        end
        if (fl || (!fz && !in_s.valid)) exp_cnt = (exp_cnt + 1 > 255) ? 255 : exp_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1; flush = 0; freeze = 0; in_s = '0;
        exp_s = '0; exp_cnt = 0;
        #2;
        n_checks++;
        if (got !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", got); end
        n_checks++;
        if (bubble_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt); end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_load;
        in_s = '0;
        in_s.valid = 1; in_s.pc = 32'h10; in_s.reg1 = 32'h5; in_s.reg2 = 32'h7;
        in_s.wb_en = 1; in_s.exe_cmd = 4'h2;
        step(0, 0);
        n_checks++;
        if (got !== in_s) begin n_fail++; $display("FAIL load_outputs got=%h exp=%h", got, in_s); end
        n_checks++;
        if (bubble_cnt !== 8'd0) begin n_fail++; $display("FAIL load_cnt got=%0d exp=0", bubble_cnt); end
    endtask

    task automatic test_freeze;
        in_s.pc = 32'h14;
        for (int i = 0; i < 3; i++) begin
            step(0, 1);
            n_checks++;
            if (pc_out !== 32'h10 || bubble_cnt !== 8'd0) begin
                n_fail++; $display("FAIL freeze_hold cyc=%0d pc=%h cnt=%0d exp pc=10 cnt=0", i, pc_out, bubble_cnt);
            end
        end
        step(0, 0);
        n_checks++;
        if (pc_out !== 32'h14) begin n_fail++; $display("FAIL freeze_release pc=%h exp=14", pc_out); end
    endtask

    task automatic test_flush_freeze;
        in_s.wb_en = 1; in_s.mem_w_en = 1;
        step(1, 1);
        n_checks++;
        if (got !== '0) begin n_fail++; $display("FAIL flush_freeze_outputs got=%h exp=0", got); end
        n_checks++;
        if (bubble_cnt !== 8'd1) begin n_fail++; $display("FAIL flush_freeze_cnt got=%0d exp=1", bubble_cnt); end
    endtask

    task automatic test_invalid;
        in_s = '0;
        in_s.mem_r_en = 1; in_s.reg1 = 32'hAB; in_s.wb_en = 1; in_s.b = 1;
        step(0, 0);
        n_checks++;
        if (mem_r_en_out !== 1'b0 || wb_en_out !== 1'b0 || b_out !== 1'b0 || reg1_out !== 32'hAB) begin
            n_fail++; $display("FAIL invalid_gate mem_r=%b wb=%b b=%b reg1=%h exp 0 0 0 ab",
                               mem_r_en_out, wb_en_out, b_out, reg1_out);
        end
        n_checks++;
        if (bubble_cnt !== 8'd2) begin n_fail++; $display("FAIL invalid_cnt got=%0d exp=2", bubble_cnt); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 200; i++) begin
            in_s = stage_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            in_s.valid = ($urandom_range(3) != 0);
            step($urandom_range(7) == 0, $urandom_range(3) == 0);
            n_checks++;
            if (got !== exp_s || bubble_cnt !== 8'(exp_cnt)) begin
                n_fail++; $display("FAIL random cyc=%0d got=%h cnt=%0d exp=%h cnt=%0d", i, got, bubble_cnt, exp_s, exp_cnt);
            end
            n_checks++;
            if (!valid_out && (wb_en_out || mem_r_en_out || mem_w_en_out || b_out || s_out)) begin
                n_fail++; $display("FAIL ctrl_without_valid cyc=%0d ctrl=%b%b%b%b%b exp=00000", i,
                                   wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out);
            end
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++) begin
            step(1, 1'($urandom));
            n_checks++;
            if (bubble_cnt !== 8'(exp_cnt)) begin
                n_fail++; $display("FAIL saturation cyc=%0d got=%0d exp=%0d", i, bubble_cnt, exp_cnt);
            end
        end
        n_checks++;
        if (bubble_cnt !== 8'd255) begin n_fail++; $display("FAIL saturation_final got=%0d exp=255", bubble_cnt); end
    endtask

    task automatic test_async_reset;
        in_s = '0;
        in_s.valid = 1; in_s.pc = 32'h100; in_s.reg2 = 32'hDEAD; in_s.mem_w_en = 1; in_s.status = 4'hA;
        step(0, 0);
        step(0, 1);
        n_checks++;
        if (got !== exp_s) begin n_fail++; $display("FAIL async_preload got=%h exp=%h", got, exp_s); end
        #3 rst = 1;
        exp_s = '0; exp_cnt = 0;
        #1;
        n_checks++;
        if (got !== '0 || bubble_cnt !== 8'd0) begin
            n_fail++; $display("FAIL async_reset got=%h cnt=%0d exp=0 cnt=0", got, bubble_cnt);
        end
        @(posedge clk); #1;
        rst = 0;
        in_s.pc = 32'h200;
        step(0, 0);
        n_checks++;
        if (got !== exp_s || bubble_cnt !== 8'd0) begin
            n_fail++; $display("FAIL post_reset_load got=%h cnt=%0d exp=%h cnt=0", got, bubble_cnt, exp_s);
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_freeze;
        test_flush_freeze;
        test_invalid;
        test_random;
        test_saturation;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
